decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
Pipelined, parametrised successor to the single-cycle RV32I decoder. It accepts fetched instructions over a valid/ready handshake and registers the decoded control bundle into a one-entry ID/EX pipeline register. It detects load-use hazards against the EX stage and supports branch flush. It sits between the fetch stage and the execute stage of the pipelined core.

Parameters:
XLEN, 32, datapath/immediate width; imm32 is sign-extended to XLEN.
REG_AW, 5, register-select width.
ALUC_W, 6, ALU_Control width.

Ports:
clock  in  1  rising-edge clock.
reset  in  1  asynchronous, active-low reset (0 = reset asserted).
in_valid  in  1  fetch presents an instruction.
in_ready  out  1  stage accepts the instruction this cycle.
instruction  in  32  fetched instruction word.
pc_in  in  XLEN  PC of the instruction.
out_valid  out  1  registered bundle is valid.
out_ready  in  1  EX consumes the bundle this cycle.
pc_out  out  XLEN  registered PC.
wb_sel  out  1  1 = write back memory data (load).
read_sel1 / read_sel2  out  REG_AW  rs1 / rs2.
write_sel  out  REG_AW  rd.
wEn  out  1  register-file write enable.
imm32  out  XLEN  sign-extended immediate.
op_B_sel  out  1  1 = ALU operand B is the immediate.
ALU_Control  out  ALUC_W  ALU operation code.
mem_wEn  out  1  data-memory write enable.
illegal  out  1  unsupported opcode or funct.
ex_load_valid  in  1  EX holds a valid load.
ex_load_rd  in  REG_AW  destination register of that load.
flush  in  1  squash the registered and the incoming instruction.

Behaviour:
- Reset (reset=0, asynchronous): out_valid=0 and every registered output is 0.
- Supported opcodes: OP (0110011), OP-IMM (0010011), LOAD/LW (0000011), STORE/SW (0100011), LUI (0110111).
  - Any other opcode, or an unsupported funct3/funct7: illegal=1, with wEn=0 and mem_wEn=0 forced.
- Immediates are sign-extended to XLEN:
  - I-type: instr[31:20].
  - S-type: {instr[31:25], instr[11:7]}.
  - LUI: {instr[31:12], 12'b0}.
  - R-type: imm32=0.
- Operand usage:
  - rs1 is used by OP, OP-IMM, LOAD and STORE.
  - rs2 is used by OP and STORE.
  - Unused selects are driven 0.
  - For LUI, read_sel1=0 and ALU_Control=ADD.
- Hazard: hazard = ex_load_valid && ex_load_rd!=0 && (ex_load_rd matches a used rs1 or rs2 of the incoming instruction).
- Advance condition: adv = !out_valid || out_ready.
- Ready logic: in_ready = adv && !hazard, or 1 when flush=1 (the incoming word is dropped).
- Register update on each clock edge, in priority order:
  1. flush=1 → out_valid<=0; the incoming instruction is discarded.
  2. Else if adv && in_valid && !hazard → load the decoded bundle and set out_valid<=1.
  3. Else if adv → out_valid<=0 (a bubble is inserted on hazard or when in_valid=0).
  4. Else hold all outputs stable.
- Latency: exactly one cycle from acceptance to out_valid.
- Throughput: one instruction per cycle while out_ready=1 and there is no hazard.
- Bubble contents: when out_valid=0, wEn and mem_wEn are forced to 0 at the output.
- Registered fields may keep stale values while out_valid=0.
- A reset asserted mid-stall or mid-flush has immediate effect and overrides everything.

Decomposition:
- Package decode_pkg holds:
  - opcode constants;
  - ALU_Control constants: ADD=6'b000000, SUB=6'b001000, SLL=6'b000001, SLT=6'b000010, SLTU=6'b000011, XOR=6'b000100, SRL=6'b000101, SRA=6'b001101, OR=6'b000110, AND=6'b000111;
  - the decoded-bundle struct typedef.
- Sub-module decode_comb: purely combinational instruction→bundle decoder, which also produces the rs-used flags.
- decode_stage itself owns the handshake, hazard and flush logic and the pipeline register.

Test Plan:
1. Reset: hold reset=0 for 2 cycles → out_valid=0, wEn=0, mem_wEn=0, imm32=0; release reset → in_ready=1.
2. Accept `addi a1,zero,-1` (0xFFF00593) with in_valid=1 and out_ready=1 → next cycle: out_valid=1, write_sel=11, read_sel1=0, imm32=0xFFFFFFFF, op_B_sel=1, wEn=1, ALU_Control=ADD, mem_wEn=0.
3. Backpressure: out_valid=1, out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and every output is unchanged for all 3 cycles.
4. Load-use stall: ex_load_valid=1, ex_load_rd=11, in `add a2,a1,a0` (0x00A58633) → in_ready=0 and out_valid=0 the next cycle; drop ex_load_valid → accepted, then read_sel1=11, read_sel2=10, write_sel=12, op_B_sel=0, ALU_Control=ADD.
5. Store: `sw a0,-4(sp)` (0xFEA12E23) → imm32=0xFFFFFFFC, read_sel1=2, read_sel2=10, mem_wEn=1, wEn=0, op_B_sel=1. Flush: flush=1 with out_valid=1 and in_valid=1 → next cycle out_valid=0 and the incoming instruction never appears.
6. Illegal: 0xFFFFFFFF → out_valid=1, illegal=1, wEn=0, mem_wEn=0.

Source files
------------

// File: rtl/decode_pkg.sv
// decode_pkg: shared opcode and ALU_Control constants and the decoded
// control bundle carried from the decoder into the ID/EX register.
package decode_pkg;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;

    localparam logic [5:0] ALU_ADD  = 6'b000000;
    localparam logic [5:0] ALU_SUB  = 6'b001000;
    localparam logic [5:0] ALU_SLL  = 6'b000001;
    localparam logic [5:0] ALU_SLT  = 6'b000010;
    localparam logic [5:0] ALU_SLTU = 6'b000011;
    localparam logic [5:0] ALU_XOR  = 6'b000100;
    localparam logic [5:0] ALU_SRL  = 6'b000101;
    localparam logic [5:0] ALU_SRA  = 6'b001101;
    localparam logic [5:0] ALU_OR   = 6'b000110;
    localparam logic [5:0] ALU_AND  = 6'b000111;

    // Register fields are 5 bits because the RV32I encoding fixes them.
    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [5:0] alu;
        logic       wen;
        logic       mem_wen;
        logic       wb_sel;
        logic       op_b_sel;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/decode_comb.sv
// decode_comb: combinational RV32I subset decoder.
// Ports: instr in; ctrl bundle, XLEN immediate and rs-used flags out.
module decode_comb
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output dec_t            ctrl,
    output logic [XLEN-1:0] imm,
    output logic            use_rs1,
    output logic            use_rs2
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       f7_zero;
    logic       f7_alt;

    assign opc     = instr[6:0];
    assign f3      = instr[14:12];
    assign f7      = instr[31:25];
    assign f7_zero = (f7 == 7'h00);
    assign f7_alt  = (f7 == 7'h20);

    always_comb begin
        ctrl    = '0;
        imm     = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        unique case (1'b1)
            (opc == OPC_OP): begin
                // funct7=0x20 only selects SUB and SRA
                if (f7_zero || (f7_alt && (f3 == 3'd0 || f3 == 3'd5))) begin
                    ctrl.rs1 = instr[19:15];
                    ctrl.rs2 = instr[24:20];
                    ctrl.rd  = instr[11:7];
                    ctrl.wen = 1'b1;
                    ctrl.alu = {2'b00, f7_alt, f3};
                    use_rs1  = 1'b1;
                    use_rs2  = 1'b1;
                end else begin
                    ctrl.illegal = 1'b1;
                end
            end
            (opc == OPC_OPIMM): begin
                // shift-immediates constrain the upper immediate bits
                if ((f3 == 3'd1 && !f7_zero) ||
                    (f3 == 3'd5 && !(f7_zero || f7_alt))) begin
                    ctrl.illegal = 1'b1;
                end else begin
                    ctrl.rs1      = instr[19:15];
                    ctrl.rd       = instr[11:7];
                    ctrl.wen      = 1'b1;
                    ctrl.op_b_sel = 1'b1;
                    ctrl.alu      = {2'b00, (f3 == 3'd5) && f7_alt, f3};
                    imm           = XLEN'($signed(instr[31:20]));
                    use_rs1       = 1'b1;
                end
            end
            (opc == OPC_LOAD): begin
                if (f3 == 3'd2) begin
                    ctrl.rs1      = instr[19:15];
                    ctrl.rd       = instr[11:7];
                    ctrl.wen      = 1'b1;
                    ctrl.wb_sel   = 1'b1;
                    ctrl.op_b_sel = 1'b1;
                    ctrl.alu      = ALU_ADD;
                    imm           = XLEN'($signed(instr[31:20]));
                    use_rs1       = 1'b1;
                end else begin
                    ctrl.illegal = 1'b1;
                end
            end
            (opc == OPC_STORE): begin
                if (f3 == 3'd2) begin
                    ctrl.rs1      = instr[19:15];
                    ctrl.rs2      = instr[24:20];
                    ctrl.mem_wen  = 1'b1;
                    ctrl.op_b_sel = 1'b1;
                    ctrl.alu      = ALU_ADD;
                    imm           = XLEN'($signed({instr[31:25], instr[11:7]}));
                    use_rs1       = 1'b1;
                    use_rs2       = 1'b1;
                end else begin
                    ctrl.illegal = 1'b1;
                end
            end
            (opc == OPC_LUI): begin
                // x0 + imm through the ALU
                ctrl.rd       = instr[11:7];
                ctrl.wen      = 1'b1;
                ctrl.op_b_sel = 1'b1;
                ctrl.alu      = ALU_ADD;
                imm           = XLEN'($signed({instr[31:12], 12'b0}));
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: pipelined decode with valid/ready handshake, load-use
// hazard stall, flush, and a one-entry ID/EX register.
// Ports: clock/reset, fetch side (in_valid/in_ready/instruction/pc_in),
// EX side (out_valid/out_ready + decoded fields), EX load info, flush.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int ALUC_W = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instruction,
    input  logic [XLEN-1:0]   pc_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   pc_out,
    output logic              wb_sel,
    output logic [REG_AW-1:0] read_sel1,
    output logic [REG_AW-1:0] read_sel2,
    output logic [REG_AW-1:0] write_sel,
    output logic              wEn,
    output logic [XLEN-1:0]   imm32,
    output logic              op_B_sel,
    output logic [ALUC_W-1:0] ALU_Control,
    output logic              mem_wEn,
    output logic              illegal,
    input  logic              ex_load_valid,
    input  logic [REG_AW-1:0] ex_load_rd,
    input  logic              flush
);

    dec_t            dec;
    logic [XLEN-1:0] dec_imm;
    logic            use_rs1;
    logic            use_rs2;

    decode_comb #(.XLEN(XLEN)) u_dec (
        .instr   (instruction),
        .ctrl    (dec),
        .imm     (dec_imm),
        .use_rs1 (use_rs1),
        .use_rs2 (use_rs2)
    );

    logic            valid_q, valid_d;
    dec_t            ctrl_q, ctrl_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [XLEN-1:0] pc_q, pc_d;

    logic adv;
    logic hazard;

    assign adv    = !valid_q || out_ready;
    assign hazard = ex_load_valid && (ex_load_rd != '0) &&
                    ((use_rs1 && ex_load_rd == REG_AW'(dec.rs1)) ||
                     (use_rs2 && ex_load_rd == REG_AW'(dec.rs2)));
    // during flush the incoming word is taken and dropped
    assign in_ready = flush || (adv && !hazard);

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        imm_d   = imm_q;
        pc_d    = pc_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (adv && in_valid && !hazard) begin
            valid_d = 1'b1;
            ctrl_d  = dec;
            imm_d   = dec_imm;
            pc_d    = pc_in;
        end else if (adv) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            imm_q   <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            imm_q   <= imm_d;
            pc_q    <= pc_d;
        end
    end

    assign out_valid   = valid_q;
    assign pc_out      = pc_q;
    assign wb_sel      = ctrl_q.wb_sel;
    assign read_sel1   = REG_AW'(ctrl_q.rs1);
    assign read_sel2   = REG_AW'(ctrl_q.rs2);
    assign write_sel   = REG_AW'(ctrl_q.rd);
    assign wEn         = valid_q && ctrl_q.wen;
    assign imm32       = imm_q;
    assign op_B_sel    = ctrl_q.op_b_sel;
    assign ALU_Control = ALUC_W'(ctrl_q.alu);
    assign mem_wEn     = valid_q && ctrl_q.mem_wen;
    assign illegal     = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized checks of decode_stage
// against a behavioural decode/pipeline model.
module tb_decode_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction;
    logic [31:0] pc_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] pc_out;
    logic        wb_sel;
    logic [4:0]  read_sel1;
    logic [4:0]  read_sel2;
    logic [4:0]  write_sel;
    logic        wEn;
    logic [31:0] imm32;
    logic        op_B_sel;
    logic [5:0]  ALU_Control;
    logic        mem_wEn;
    logic        illegal;
    logic        ex_load_valid;
    logic [4:0]  ex_load_rd;
    logic        flush;

    decode_stage dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .pc_in(pc_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .pc_out(pc_out), .wb_sel(wb_sel),
        .read_sel1(read_sel1), .read_sel2(read_sel2),
        .write_sel(write_sel), .wEn(wEn), .imm32(imm32),
        .op_B_sel(op_B_sel), .ALU_Control(ALU_Control),
        .mem_wEn(mem_wEn), .illegal(illegal),
        .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd),
        .flush(flush)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [5:0]  alu;
        logic        wen;
        logic        mw;
        logic        wb;
        logic        opb;
        logic        ill;
        logic        u1;
        logic        u2;
    } exp_t;

    int n_chk  = 0;
    int n_pass = 0;

    logic        mv;
    exp_t        mb;
    logic [31:0] mpc;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    endtask

    function automatic logic [5:0] alu_of(input logic [2:0] f3,
                                          input logic alt);
        case (f3)
            3'd0: return alt ? 6'd8 : 6'd0;
            3'd1: return 6'd1;
            3'd2: return 6'd2;
            3'd3: return 6'd3;
            3'd4: return 6'd4;
            3'd5: return alt ? 6'd13 : 6'd5;
            3'd6: return 6'd6;
            default: return 6'd7;
        endcase
    endfunction

    function automatic exp_t ref_dec(input logic [31:0] w);
        exp_t e;
        logic [2:0] f3;
        logic [6:0] f7;
        e  = '0;
        f3 = w[14:12];
        f7 = w[31:25];
        case (w[6:0])
            7'h33: begin
                if (f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5))) begin
                    e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7];
                    e.u1 = 1; e.u2 = 1; e.wen = 1;
                    e.alu = alu_of(f3, f7 == 7'h20);
                end else e.ill = 1;
            end
            7'h13: begin
                if (f3 == 1 && f7 != 0) e.ill = 1;
                else if (f3 == 5 && f7 != 0 && f7 != 7'h20) e.ill = 1;
                else begin
                    e.rs1 = w[19:15]; e.rd = w[11:7]; e.u1 = 1;
                    e.wen = 1; e.opb = 1;
                    e.alu = alu_of(f3, f3 == 5 && f7 == 7'h20);
                    e.imm = {{20{w[31]}}, w[31:20]};
                end
            end
            7'h03: begin
                if (f3 == 2) begin
                    e.rs1 = w[19:15]; e.rd = w[11:7]; e.u1 = 1;
                    e.wen = 1; e.wb = 1; e.opb = 1;
                    e.imm = {{20{w[31]}}, w[31:20]};
                end else e.ill = 1;
            end
            7'h23: begin
                if (f3 == 2) begin
                    e.rs1 = w[19:15]; e.rs2 = w[24:20];
                    e.u1 = 1; e.u2 = 1; e.mw = 1; e.opb = 1;
                    e.imm = {{20{w[31]}}, w[31:25], w[11:7]};
                end else e.ill = 1;
            end
            7'h37: begin
                e.rd = w[11:7]; e.wen = 1; e.opb = 1;
                e.imm = w & 32'hFFFFF000;
            end
            default: e.ill = 1;
        endcase
        return e;
    endfunction

    task automatic cmp_outputs();
        chk("out_valid", out_valid, mv);
        chk("wEn", wEn, mv & mb.wen);
        chk("mem_wEn", mem_wEn, mv & mb.mw);
        if (mv) begin
            chk("pc_out", pc_out, mpc);
            chk("wb_sel", wb_sel, mb.wb);
            chk("read_sel1", read_sel1, mb.rs1);
            chk("read_sel2", read_sel2, mb.rs2);
            chk("write_sel", write_sel, mb.rd);
            chk("imm32", imm32, mb.imm);
            chk("op_B_sel", op_B_sel, mb.opb);
            chk("ALU_Control", ALU_Control, mb.alu);
            chk("illegal", illegal, mb.ill);
        end
    endtask

    // inputs are already driven; check in_ready, clock, update model
    task automatic step();
        exp_t d;
        logic adv;
        logic haz;
        #1;
        d   = ref_dec(instruction);
        adv = !mv || out_ready;
        haz = ex_load_valid && ex_load_rd != 0 &&
              ((d.u1 && d.rs1 == ex_load_rd) ||
               (d.u2 && d.rs2 == ex_load_rd));
        chk("in_ready", in_ready, flush || (adv && !haz));
        @(posedge clock);
        #1;
        if (flush) mv = 0;
        else if (adv && in_valid && !haz) begin
            mv = 1; mb = d; mpc = pc_in;
        end else if (adv) mv = 0;
        cmp_outputs();
    endtask

    function automatic logic [4:0] rreg();
        return ($urandom_range(0, 3) == 0) ? 5'($urandom)
                                           : 5'($urandom_range(0, 3));
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [2:0] f3;
        logic [6:0] f7;
        logic [6:0] alt;
        f3  = 3'($urandom);
        f7  = 7'($urandom);
        alt = $urandom_range(0, 1) ? 7'h20 : 7'h00;
        case ($urandom_range(0, 9))
            0, 1: return {alt, rreg(), rreg(), f3, rreg(), 7'h33};
            2, 3: return {($urandom_range(0, 2) == 0) ? f7 : alt,
                          rreg(), rreg(), f3, rreg(), 7'h13};
            4:    return {f7, rreg(), rreg(),
                          $urandom_range(0, 3) == 0 ? f3 : 3'd2,
                          rreg(), 7'h03};
            5:    return {f7, rreg(), rreg(),
                          $urandom_range(0, 3) == 0 ? f3 : 3'd2,
                          rreg(), 7'h23};
            6:    return {20'($urandom), rreg(), 7'h37};
            7:    return $urandom;
            8:    return {f7, rreg(), rreg(), f3, rreg(), 7'h33};
            default: return {f7, rreg(), rreg(), f3, rreg(), 7'h13};
        endcase
    endfunction

    initial begin
        reset         = 0;
        in_valid      = 0;
        instruction   = 0;
        pc_in         = 0;
        out_ready     = 0;
        ex_load_valid = 0;
        ex_load_rd    = 0;
        flush         = 0;
        mv            = 0;
        mb            = '0;
        mpc           = 0;

        // reset
        repeat (2) @(posedge clock);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_wEn", wEn, 0);
        chk("rst_mem_wEn", mem_wEn, 0);
        chk("rst_imm32", imm32, 0);
        reset = 1;
        #1;
        chk("rst_in_ready", in_ready, 1);

        // addi a1,zero,-1
        instruction = 32'hFFF00593; pc_in = 32'h100;
        in_valid = 1; out_ready = 1;
        step();
        chk("addi_valid", out_valid, 1);
        chk("addi_rd", write_sel, 11);
        chk("addi_rs1", read_sel1, 0);
        chk("addi_imm", imm32, 32'hFFFFFFFF);
        chk("addi_opb", op_B_sel, 1);
        chk("addi_wen", wEn, 1);
        chk("addi_alu", ALU_Control, 0);
        chk("addi_mwen", mem_wEn, 0);

        // backpressure
        out_ready = 0; instruction = 32'h00A58633; pc_in = 32'h104;
        repeat (3) begin
            step();
            chk("bp_in_ready", in_ready, 0);
            chk("bp_imm", imm32, 32'hFFFFFFFF);
            chk("bp_pc", pc_out, 32'h100);
        end

        // load-use stall on a1
        out_ready = 1; ex_load_valid = 1; ex_load_rd = 11;
        step();
        chk("lu_valid", out_valid, 0);
        ex_load_valid = 0;
        step();
        chk("lu_rs1", read_sel1, 11);
        chk("lu_rs2", read_sel2, 10);
        chk("lu_rd", write_sel, 12);
        chk("lu_opb", op_B_sel, 0);
        chk("lu_alu", ALU_Control, 0);

        // sw a0,-4(sp)
        instruction = 32'hFEA12E23; pc_in = 32'h108;
        step();
        chk("sw_imm", imm32, 32'hFFFFFFFC);
        chk("sw_rs1", read_sel1, 2);
        chk("sw_rs2", read_sel2, 10);
        chk("sw_mwen", mem_wEn, 1);
        chk("sw_wen", wEn, 0);
        chk("sw_opb", op_B_sel, 1);

        // flush drops both registered and incoming
        flush = 1; instruction = 32'hFFF00593; pc_in = 32'h10C;
        step();
        chk("fl_valid", out_valid, 0);
        flush = 0; in_valid = 0;
        step();
        chk("fl_gone", out_valid, 0);

        // illegal
        in_valid = 1; instruction = 32'hFFFFFFFF; pc_in = 32'h110;
        step();
        chk("ill_valid", out_valid, 1);
        chk("ill_flag", illegal, 1);
        chk("ill_wen", wEn, 0);
        chk("ill_mwen", mem_wEn, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid      = ($urandom_range(0, 3) != 0);
            out_ready     = ($urandom_range(0, 3) != 0);
            ex_load_valid = ($urandom_range(0, 2) == 0);
            ex_load_rd    = 5'($urandom_range(0, 3));
            flush         = ($urandom_range(0, 19) == 0);
            instruction   = rand_instr();
            pc_in         = $urandom;
            step();
        end

        // asynchronous reset in the middle of a stall
        flush = 0; in_valid = 1; out_ready = 0;
        instruction = 32'hFFF00593;
        step();
        #2;
        reset = 0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_wEn", wEn, 0);
        chk("arst_imm", imm32, 0);
        chk("arst_pc", pc_out, 0);
        mv = 0; mb = '0; mpc = 0;
        @(negedge clock);
        reset = 1;
        out_ready = 1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
